wbs_timer: RTL and testbench
============================

Name: wbs_timer

Overview:
- Wishbone responder: the target end of the MCU's Wishbone initiator (15-bit address, 32-bit data, we/stb/ack).
- Provides an ID register, a scratch register, a prescaled 32-bit free-running counter with compare-match, and a one-cycle interrupt strobe.
- Sits outside the MCU core beside other responders on the same bus. irq_o wires to one bit of the MCU irqs input.

Parameters:
- BASE, 11'h000, adr_i[14:4] value this block decodes (16-word window).
- WAITS, 1, wait-state cycles inserted before ack_o (0..15).
- ID, 32'h0000_7131, value returned by the ID register.

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- adr_i  in  15  word address from initiator
- dat_i  in  32  write data from initiator
- dat_o  out  32  read data to initiator
- we_i  in  1  1 = write, 0 = read
- stb_i  in  1  strobe; initiator holds it and adr/dat/we stable until ack
- ack_o  out  1  one-cycle acknowledge
- irq_o  out  1  one-cycle compare-match strobe

Behaviour:
- Clock and reset: one clock (clk); arstn is asynchronous, active-low.
- Reset values: all state cleared.
  - Outputs: ack_o=0, dat_o=0, irq_o=0.
  - Registers: SCRATCH=0, COUNT=0, COMPARE=0, CTRL=0 (timer disabled), STATUS=0.
  - FSM enters IDLE.
  - Reset mid-transaction aborts it; no ack is issued for it.
- Select: sel = stb_i & (adr_i[14:4]==BASE). Non-matching strobes are ignored and never acked, so responders can share the bus.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on sel, latch adr_i[3:0], we_i and dat_i. Go to WAIT if WAITS>0, else ACK.
  - WAIT: 4-bit down-counter loaded with WAITS-1. Go to ACK when it reaches 0.
  - ACK: ack_o=1 for exactly one cycle, then IDLE.
- Latency: stb_i sampled high at edge N gives ack_o high in cycle N+1+WAITS.
- End of cycle: the initiator drops stb_i on the edge that samples ack_o. IDLE then sees stb_i low, so there is no double ack. If stb_i is still high in IDLE, a new transaction starts.
- Commit timing: writes commit, and read data loads into dat_o, on the edge that raises ack_o. dat_o holds until the next read ack.
- Register map (offset adr_i[3:0]):
  - 0 ID: read-only; writes ignored.
  - 1 SCRATCH: read/write.
  - 2 COUNT: read/write; a write loads the counter.
  - 3 COMPARE: read/write.
  - 4 CTRL: bit0 = enable, bits[15:8] = prescale; other bits read 0.
  - 5 STATUS: bit0 = hit (sticky); write 1 to clear.
  - 6..15: read 0, writes ignored, still acked.
- Prescaler: 8-bit counter. A tick fires when enable=1 and the prescaler equals CTRL.prescale; the prescaler then reloads 0.
  - prescale=0 ticks every cycle.
  - enable=0 freezes both COUNT and the prescaler.
- On tick: COUNT <= COUNT+1 mod 2^32 (0xFFFFFFFF wraps to 0).
- Compare match: if COUNT+1 == COMPARE on a tick, then on that same edge irq_o<=1 for one cycle and STATUS.hit<=1.
- Simultaneous events:
  - A COUNT write wins over a tick, and no match is evaluated that cycle.
  - A hit being set wins over a STATUS W1C in the same cycle.
  - A COMPARE write takes effect for ticks from the following cycle.
- Reading COUNT returns the value before the ack-edge increment.

Decomposition:
- Shared package (wbs_pkg):
  - Register offset constants REG_ID..REG_STATUS.
  - FSM state encoding.
  - CTRL field positions.
- Sub-module tick_timer: prescaler, COUNT, compare and the hit/irq generation.
  - Inputs: load strobe plus value, compare value, enable, prescale.
  - Outputs: count, match strobe.
- The top holds the bus FSM, decode, SCRATCH/CTRL/STATUS and read mux.

Test Plan:
- WAITS=1. Write 0xDEADBEEF to BASE+1, then read BASE+1 → each ack_o lands 2 cycles after stb_i is sampled; dat_o=0xDEADBEEF. Read BASE+0 → ID.
- stb_i with adr_i[14:4]≠BASE held for 20 cycles → ack_o stays 0.
- CTRL=0x0001 (prescale 0), COUNT=0, COMPARE=5 → irq_o pulses once, 5 cycles after the CTRL ack edge. STATUS reads 1. Write 1 to STATUS → reads 0.
- CTRL prescale=3 → COUNT advances once every 4 cycles. COUNT=0xFFFFFFFF with a tick → COUNT=0, no irq (COMPARE=5).
- Hit coinciding with a STATUS W1C → STATUS stays 1. COUNT write coinciding with a tick → the written value is kept.
- arstn low during WAIT → no ack_o. After release, all registers read their reset values and a new transaction completes normally.

Source files
------------

// File: rtl/wbs_pkg.sv
// Shared definitions for the Wishbone timer responder: register offsets,
// bus FSM encoding, CTRL/STATUS field positions and datapath widths.
package wbs_pkg;

    localparam int COUNT_W = 32;
    localparam int PS_W    = 8;

    localparam logic [3:0] REG_ID      = 4'd0;
    localparam logic [3:0] REG_SCRATCH = 4'd1;
    localparam logic [3:0] REG_COUNT   = 4'd2;
    localparam logic [3:0] REG_COMPARE = 4'd3;
    localparam logic [3:0] REG_CTRL    = 4'd4;
    localparam logic [3:0] REG_STATUS  = 4'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PS_LSB    = 8;
    localparam int STATUS_HIT_BIT = 0;

    // Builds the CTRL read value; unused bits always read as zero.
    function automatic logic [31:0] ctrl_pack(input logic en, input logic [PS_W-1:0] ps);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN_BIT] = en;
        v[CTRL_PS_LSB +: PS_W] = ps;
        return v;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Prescaled free-running counter with compare-match detection.
// match is combinational so the parent can raise irq and the sticky hit
// bit on the very edge the counter reaches the compare value.
module tick_timer import wbs_pkg::*; (
    input  logic               clk,
    input  logic               arstn,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic [COUNT_W-1:0] compare,
    input  logic               enable,
    input  logic [PS_W-1:0]    prescale,
    output logic [COUNT_W-1:0] count,
    output logic               match
);

    logic [PS_W-1:0]    ps_cnt;
    logic               tick;
    logic [COUNT_W-1:0] count_next;

    assign tick       = enable && (ps_cnt == prescale);
    assign count_next = count + {{(COUNT_W-1){1'b0}}, 1'b1};
    // A load replaces the count this cycle, so no match is judged then.
    assign match      = tick && !load && (count_next == compare);

    // Prescaler: runs only while enabled, restarts from zero after each tick.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ps_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + {{(PS_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Main counter: a bus load takes priority over a tick; wraps naturally.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/wbs_timer.sv
// Wishbone responder exposing ID, SCRATCH, a prescaled 32-bit timer with
// compare-match, CTRL and a sticky STATUS hit bit. Acks after WAITS wait
// states; writes commit and read data loads on the edge that raises ack_o.
module wbs_timer import wbs_pkg::*; #(
    parameter logic [10:0] BASE  = 11'h000,
    parameter int unsigned WAITS = 1,
    parameter logic [31:0] ID    = 32'h0000_7131
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [14:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        irq_o
);

    localparam logic [3:0] WAIT_LOAD = (WAITS > 0) ? 4'(WAITS - 1) : 4'd0;

    logic [1:0]         state;
    logic [3:0]         wait_cnt;
    logic [3:0]         off_q;
    logic               we_q;
    logic [31:0]        wdat_q;

    logic [31:0]        scratch;
    logic [COUNT_W-1:0] compare;
    logic               ctrl_en;
    logic [PS_W-1:0]    ctrl_ps;
    logic               hit;

    logic               sel;
    logic               commit;
    logic               wr;
    logic               rd;
    logic               count_load;
    logic               status_clr;
    logic [COUNT_W-1:0] count;
    logic               match;
    logic [31:0]        rdata;

    assign sel        = stb_i && (adr_i[14:4] == BASE);
    assign commit     = (state == ST_ACK);
    assign wr         = commit && we_q;
    assign rd         = commit && !we_q;
    assign count_load = wr && (off_q == REG_COUNT);
    assign status_clr = wr && (off_q == REG_STATUS) && wdat_q[STATUS_HIT_BIT];

    tick_timer u_tick_timer (
        .clk      (clk),
        .arstn    (arstn),
        .load     (count_load),
        .load_val (wdat_q),
        .compare  (compare),
        .enable   (ctrl_en),
        .prescale (ctrl_ps),
        .count    (count),
        .match    (match)
    );

    // Bus FSM: capture request in IDLE, count wait states, then one ACK cycle.
    // IDLE ignores the strobe while ack_o is high because the initiator only
    // drops stb_i on the edge that samples the ack.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            off_q    <= '0;
            we_q     <= 1'b0;
            wdat_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel && !ack_o) begin
                        off_q  <= adr_i[3:0];
                        we_q   <= we_i;
                        wdat_q <= dat_i;
                        if (WAITS > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ST_ACK;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Acknowledge: registered so it rises on the same edge the access commits.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ack_o <= 1'b0;
        end else begin
            ack_o <= commit;
        end
    end

    // Writable registers: SCRATCH, COMPARE and CTRL update on a write commit.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scratch <= '0;
            compare <= '0;
            ctrl_en <= 1'b0;
            ctrl_ps <= '0;
        end else if (wr) begin
            case (off_q)
                REG_SCRATCH: scratch <= wdat_q;
                REG_COMPARE: compare <= wdat_q;
                REG_CTRL: begin
                    ctrl_en <= wdat_q[CTRL_EN_BIT];
                    ctrl_ps <= wdat_q[CTRL_PS_LSB +: PS_W];
                end
                default: ;
            endcase
        end
    end

    // Sticky hit and one-cycle irq; a new hit beats a simultaneous clear.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hit   <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            irq_o <= match;
            if (match) begin
                hit <= 1'b1;
            end else if (status_clr) begin
                hit <= 1'b0;
            end
        end
    end

    // Read mux: COUNT returns the value held before this edge's increment.
    always_comb begin
        rdata = '0;
        case (off_q)
            REG_ID:      rdata = ID;
            REG_SCRATCH: rdata = scratch;
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_CTRL:    rdata = ctrl_pack(ctrl_en, ctrl_ps);
            REG_STATUS:  rdata[STATUS_HIT_BIT] = hit;
            default:     rdata = '0;
        endcase
    end

    // Read data register: loads on a read commit and holds until the next one.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            dat_o <= '0;
        end else if (rd) begin
            dat_o <= rdata;
        end
    end

endmodule

// File: tb/tb_wbs_timer.sv
// Directed bench for wbs_timer: a register-access vector table followed by
// hand-timed sequences for the timer, irq, simultaneous events and reset.
module tb_wbs_timer;
    import wbs_pkg::*;

    localparam logic [10:0] TB_BASE = 11'h05A;
    localparam logic [31:0] TB_ID   = 32'h0000_7131;

    logic        clk;
    logic        arstn;
    logic [14:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we_i;
    logic        stb_i;
    logic        ack_o;
    logic        irq_o;

    int compared;
    int mismatched;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  off;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    wbs_timer #(
        .BASE  (TB_BASE),
        .WAITS (1),
        .ID    (TB_ID)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop against any unforeseen hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transfer. Called 1ns after an edge; the next edge samples stb.
    // Returns ack latency in edges after the sampling edge (-1 on timeout),
    // holds stb through the edge that samples the ack, then drops it.
    task automatic applyStimulus(input logic we, input logic [14:0] adr, input logic [31:0] wdat,
                                 output logic [31:0] rdata, output int lat);
        int k;
        bit acked;
        adr_i = adr;
        we_i  = we;
        dat_i = wdat;
        stb_i = 1'b1;
        acked = 1'b0;
        k     = 0;
        lat   = -1;
        rdata = 32'hxxxx_xxxx;
        while (!acked && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (ack_o) begin
                acked = 1'b1;
                lat   = k - 1;
                rdata = dat_o;
            end
        end
        @(posedge clk);
        #1;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic regWrite(input logic [3:0] off, input logic [31:0] wdat);
        logic [31:0] rd;
        int lat;
        applyStimulus(1'b1, {TB_BASE, off}, wdat, rd, lat);
        checkOutput($sformatf("wr_lat_off%0d", off), 32'(lat), 32'd2);
    endtask

    task automatic regRead(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        applyStimulus(1'b0, {TB_BASE, off}, 32'h0, rd, lat);
        checkOutput({name, "_lat"}, 32'(lat), 32'd2);
        checkOutput(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int acks;
        int first;
        int highs;

        compared   = 0;
        mismatched = 0;

        vecs[0]  = '{"wr_scratch",      1'b1, REG_SCRATCH, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{"rd_scratch",      1'b0, REG_SCRATCH, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{"rd_id",           1'b0, REG_ID,      32'h0,         32'h0000_7131};
        vecs[3]  = '{"wr_id_ignored",   1'b1, REG_ID,      32'h1234_5678, 32'h0000_7131};
        vecs[4]  = '{"rd_id_again",     1'b0, REG_ID,      32'h0,         32'h0000_7131};
        vecs[5]  = '{"wr_ctrl_ps_only", 1'b1, REG_CTRL,    32'hFFFF_FF00, 32'h0000_7131};
        vecs[6]  = '{"rd_ctrl_masked",  1'b0, REG_CTRL,    32'h0,         32'h0000_FF00};
        vecs[7]  = '{"wr_ctrl_zero",    1'b1, REG_CTRL,    32'h0,         32'h0000_FF00};
        vecs[8]  = '{"rd_ctrl_zero",    1'b0, REG_CTRL,    32'h0,         32'h0000_0000};
        vecs[9]  = '{"wr_off9",         1'b1, 4'd9,        32'hA5A5_A5A5, 32'h0000_0000};
        vecs[10] = '{"rd_off9",         1'b0, 4'd9,        32'h0,         32'h0000_0000};
        vecs[11] = '{"rd_off15",        1'b0, 4'd15,       32'h0,         32'h0000_0000};
        vecs[12] = '{"wr_compare",      1'b1, REG_COMPARE, 32'h0000_0005, 32'h0000_0000};
        vecs[13] = '{"rd_compare",      1'b0, REG_COMPARE, 32'h0,         32'h0000_0005};
        vecs[14] = '{"wr_count",        1'b1, REG_COUNT,   32'h1234_5678, 32'h0000_0005};
        vecs[15] = '{"rd_count_frozen", 1'b0, REG_COUNT,   32'h0,         32'h1234_5678};
        vecs[16] = '{"rd_status",       1'b0, REG_STATUS,  32'h0,         32'h0000_0000};

        arstn = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        adr_i = '0;
        dat_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
        checkOutput("reset_ack", {31'b0, ack_o}, 32'd0);
        checkOutput("reset_dat", dat_o, 32'd0);
        checkOutput("reset_irq", {31'b0, irq_o}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] register access table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].we, {TB_BASE, vecs[i].off}, vecs[i].wdat, rd, lat);
            checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'd2);
            checkOutput(vecs[i].name, rd, vecs[i].exp);
        end

        $display("[TB] foreign-address strobes");
        acks  = 0;
        adr_i = {TB_BASE + 11'd1, 4'd1};
        we_i  = 1'b0;
        stb_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ack_o) acks++;
        end
        adr_i = {TB_BASE ^ 11'h400, 4'd0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ack_o) acks++;
        end
        stb_i = 1'b0;
        checkOutput("nomatch_acks", 32'(acks), 32'd0);

        $display("[TB] compare match with prescale 0");
        regWrite(REG_COMPARE, 32'd5);
        regWrite(REG_COUNT, 32'd0);
        regWrite(REG_CTRL, 32'h0000_0001);
        first = 0;
        highs = 0;
        for (int rel = 1; rel <= 9; rel++) begin
            if (irq_o) begin
                highs++;
                if (first == 0) first = rel;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("irq_edge", 32'(first), 32'd5);
        checkOutput("irq_pulses", 32'(highs), 32'd1);
        regRead("status_hit", REG_STATUS, 32'd1);
        regWrite(REG_STATUS, 32'd1);
        regRead("status_cleared", REG_STATUS, 32'd0);

        $display("[TB] prescale 3");
        regWrite(REG_CTRL, 32'h0);
        regWrite(REG_COUNT, 32'd0);
        regWrite(REG_CTRL, 32'h0000_0301);
        waitCycles(1);
        regRead("ps3_count_a", REG_COUNT, 32'd1);
        regRead("ps3_count_b", REG_COUNT, 32'd2);
        waitCycles(3);
        regWrite(REG_CTRL, 32'h0);
        regRead("ps3_count_frozen", REG_COUNT, 32'd4);

        $display("[TB] counter wrap");
        regWrite(REG_COUNT, 32'hFFFF_FFFF);
        regWrite(REG_CTRL, 32'h0000_0001);
        checkOutput("wrap_no_irq", {31'b0, irq_o}, 32'd0);
        regWrite(REG_CTRL, 32'h0);
        regRead("wrap_count", REG_COUNT, 32'd3);
        regRead("wrap_status", REG_STATUS, 32'd0);

        $display("[TB] hit versus clear on the same edge");
        regWrite(REG_COUNT, 32'd0);
        regWrite(REG_COMPARE, 32'd4);
        regWrite(REG_CTRL, 32'h0000_0001);
        regWrite(REG_STATUS, 32'd1);
        regRead("hit_beats_clear", REG_STATUS, 32'd1);

        $display("[TB] count write versus tick on the same edge");
        regWrite(REG_COUNT, 32'h0000_0100);
        regWrite(REG_CTRL, 32'h0);
        regRead("load_beats_tick", REG_COUNT, 32'h0000_0104);

        $display("[TB] reset during wait state");
        regWrite(REG_SCRATCH, 32'hCAFE_F00D);
        adr_i = {TB_BASE, REG_SCRATCH};
        we_i  = 1'b0;
        stb_i = 1'b1;
        acks  = 0;
        @(posedge clk);
        #1;
        arstn = 1'b0;
        #1;
        if (ack_o) acks++;
        stb_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (ack_o) acks++;
        end
        @(negedge clk);
        arstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack_o) acks++;
        end
        checkOutput("abort_acks", 32'(acks), 32'd0);
        checkOutput("abort_dat", dat_o, 32'd0);
        checkOutput("abort_irq", {31'b0, irq_o}, 32'd0);
        regRead("rst_scratch", REG_SCRATCH, 32'd0);
        regRead("rst_count", REG_COUNT, 32'd0);
        regRead("rst_compare", REG_COMPARE, 32'd0);
        regRead("rst_ctrl", REG_CTRL, 32'd0);
        regRead("rst_status", REG_STATUS, 32'd0);
        regWrite(REG_SCRATCH, 32'h1357_2468);
        regRead("post_rst_scratch", REG_SCRATCH, 32'h1357_2468);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
